// File: rtl/int_dispatch.sv
// int_dispatch: interrupt dispatch sequencer for the switch/button interrupt
// controller. Scans the 13 latched status bits round-robin, presents one
// source ID over a valid/ack handshake and, once acked or timed out, issues a
// one-cycle clear pulse to that source's status bit.
//
// Ports:
//   clk            system clock (rising edge)
//   res_n          synchronous active-low reset
//   dispatch_ena   allows new dispatches from IDLE
//   int_switch_sts latched switch status, source IDs 0..7
//   int_button_sts latched button status, source IDs 8..12
//   int_switch_clr one-cycle clear pulses to switch status bits
//   int_button_clr one-cycle clear pulses to button status bits
//   irq_valid      a source is being presented
//   irq_id         presented source ID (stable while irq_valid)
//   irq_ack        consumer took irq_id (only sampled while presenting)
//   timeout_flag   sticky: some presentation timed out
//   timeout_clr    clears timeout_flag (a same-cycle set wins)
//   svc_count      completed dispatches, acked or timed out (wraps)
module int_dispatch #(
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        dispatch_ena,
  input  logic [7:0]  int_switch_sts,
  input  logic [4:0]  int_button_sts,
  output logic [7:0]  int_switch_clr,
  output logic [4:0]  int_button_clr,
  output logic        irq_valid,
  output logic [3:0]  irq_id,
  input  logic        irq_ack,
  output logic        timeout_flag,
  input  logic        timeout_clr,
  output logic [15:0] svc_count
);

  localparam int          NSRC     = 13;
  localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);
  localparam logic [3:0]  LAST_ID  = 4'(NSRC - 1);

  typedef enum logic [2:0] {IDLE, SELECT, PRESENT, CLEAR, SETTLE} state_t;

  state_t            state, nxt;
  logic [NSRC-1:0]   pend;
  logic [NSRC-1:0]   clr_q;
  logic [3:0]        rr_ptr;
  logic [3:0]        win_id;
  logic              win_found;
  logic [4:0]        idx;
  logic [15:0]       tcnt;
  logic              tmo_hit;

  assign pend           = {int_button_sts, int_switch_sts};
  assign int_switch_clr = clr_q[7:0];
  assign int_button_clr = clr_q[12:8];

  // Round-robin pick: first set bit scanning upward from rr_ptr, wrapping
  // 12 -> 0. rr_ptr never exceeds 12, so one subtraction wraps the index.
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int i = 0; i < NSRC; i++) begin
      idx = {1'b0, rr_ptr} + 5'(i);
      if (idx >= 5'(NSRC)) idx = idx - 5'(NSRC);
      if (!win_found && pend[idx[3:0]]) begin
        win_found = 1'b1;
        win_id    = idx[3:0];
      end
    end
  end

  // Next-state logic. Ack has priority over the timeout on the same cycle.
  always_comb begin
    nxt     = state;
    tmo_hit = 1'b0;
    case (state)
      IDLE:    if (dispatch_ena && (|pend)) nxt = SELECT;
      SELECT:  nxt = win_found ? PRESENT : IDLE;
      PRESENT: begin
        if (irq_ack) begin
          nxt = CLEAR;
        end else if (tcnt == TMO_LAST) begin
          nxt     = CLEAR;
          tmo_hit = 1'b1;
        end
      end
      CLEAR:   nxt = SETTLE;
      SETTLE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // All outputs are registered off the next state so they line up with the
  // state they belong to (valid during PRESENT, clear pulse during CLEAR).
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state        <= IDLE;
      irq_valid    <= 1'b0;
      irq_id       <= '0;
      clr_q        <= '0;
      rr_ptr       <= '0;
      tcnt         <= '0;
      timeout_flag <= 1'b0;
      svc_count    <= '0;
    end else begin
      state     <= nxt;
      irq_valid <= (nxt == PRESENT);
      clr_q     <= '0;

      if (state == SELECT) begin
        tcnt <= '0;
        // An empty scan leaves irq_id untouched.
        if (win_found) irq_id <= win_id;
      end

      if (state == PRESENT && nxt == PRESENT) tcnt <= tcnt + 16'd1;

      if (state == PRESENT && nxt == CLEAR) begin
        clr_q     <= {{(NSRC-1){1'b0}}, 1'b1} << irq_id;
        rr_ptr    <= (irq_id == LAST_ID) ? 4'd0 : irq_id + 4'd1;
        svc_count <= svc_count + 16'd1;
      end

      if (tmo_hit)          timeout_flag <= 1'b1;
      else if (timeout_clr) timeout_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_int_dispatch.sv
module tb_int_dispatch;

  logic        clk = 1'b0;
  logic        res_n;
  logic        dispatch_ena;
  logic [7:0]  int_switch_sts;
  logic [4:0]  int_button_sts;
  logic [7:0]  int_switch_clr;
  logic [4:0]  int_button_clr;
  logic        irq_valid;
  logic [3:0]  irq_id;
  logic        irq_ack;
  logic        timeout_flag;
  logic        timeout_clr;
  logic [15:0] svc_count;

  int errors = 0;
  int checks = 0;

  int_dispatch #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .res_n(res_n), .dispatch_ena(dispatch_ena),
    .int_switch_sts(int_switch_sts), .int_button_sts(int_button_sts),
    .int_switch_clr(int_switch_clr), .int_button_clr(int_button_clr),
    .irq_valid(irq_valid), .irq_id(irq_id), .irq_ack(irq_ack),
    .timeout_flag(timeout_flag), .timeout_clr(timeout_clr),
    .svc_count(svc_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!irq_valid && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 16'(irq_valid), 16'd1);
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    tick();
    tick();
    res_n = 1'b1;
  endtask

  logic [3:0]  rr_ids [3];
  logic [12:0] model_sts;
  int          vcnt;

  initial begin
    rr_ids = '{4'd0, 4'd7, 4'd12};
    dispatch_ena   = 1'b0;
    int_switch_sts = '0;
    int_button_sts = '0;
    irq_ack        = 1'b0;
    timeout_clr    = 1'b0;
    res_n          = 1'b0;
    #1;
    do_reset();

    // Reset state
    chk("rst_valid", 16'(irq_valid), 16'd0);
    chk("rst_id", 16'(irq_id), 16'd0);
    chk("rst_swclr", 16'(int_switch_clr), 16'd0);
    chk("rst_btclr", 16'(int_button_clr), 16'd0);
    chk("rst_tflag", 16'(timeout_flag), 16'd0);
    chk("rst_svc", svc_count, 16'd0);

    // Single source: switch 2, ack on the 3rd presented cycle
    dispatch_ena   = 1'b1;
    int_switch_sts = 8'h04;
    tick();                                   // SELECT
    chk("s1_sel_valid", 16'(irq_valid), 16'd0);
    tick();                                   // PRESENT #1
    chk("s1_valid", 16'(irq_valid), 16'd1);
    chk("s1_id", 16'(irq_id), 16'd2);
    chk("s1_noclr", 16'(int_switch_clr), 16'd0);
    tick();                                   // PRESENT #2
    tick();                                   // PRESENT #3
    irq_ack = 1'b1;
    tick();                                   // CLEAR
    irq_ack = 1'b0;
    chk("s1_clr", 16'(int_switch_clr), 16'h04);
    chk("s1_clr_valid", 16'(irq_valid), 16'd0);
    chk("s1_svc", svc_count, 16'd1);
    int_switch_sts = 8'h00;
    tick();                                   // SETTLE
    chk("s1_clr_once", 16'(int_switch_clr), 16'd0);
    chk("s1_rrptr", 16'(dut.rr_ptr), 16'd3);
    chk("s1_tflag", 16'(timeout_flag), 16'd0);

    // Round-robin from pointer 0: expect IDs 0, 7, 12
    do_reset();
    int_switch_sts = 8'h81;
    int_button_sts = 5'h10;
    for (int k = 0; k < 3; k++) begin
      wait_valid("rr_valid");
      chk("rr_id", 16'(irq_id), 16'(rr_ids[k]));
      irq_ack = 1'b1;
      tick();                                 // CLEAR
      irq_ack = 1'b0;
      model_sts = {int_button_sts, int_switch_sts};
      chk("rr_clr", 16'({int_button_clr, int_switch_clr}), 16'(13'd1 << rr_ids[k]));
      model_sts[rr_ids[k]] = 1'b0;
      {int_button_sts, int_switch_sts} = model_sts;
      tick();                                 // SETTLE
      chk("rr_clr_once", 16'({int_button_clr, int_switch_clr}), 16'd0);
    end
    chk("rr_svc", svc_count, 16'd3);

    // Timeout on button 0; timeout_clr held through the timeout edge
    do_reset();
    int_button_sts = 5'h01;
    wait_valid("to_valid");
    timeout_clr = 1'b1;
    vcnt = 0;
    while (irq_valid && vcnt < 20) begin
      chk("to_id", 16'(irq_id), 16'd8);
      vcnt++;
      tick();
    end
    chk("to_cycles", 16'(vcnt), 16'd4);       // now in CLEAR
    chk("to_clr", 16'(int_button_clr), 16'h01);
    chk("to_flag_setwins", 16'(timeout_flag), 16'd1);
    chk("to_svc", svc_count, 16'd1);
    int_button_sts = 5'h00;
    tick();                                   // SETTLE, clear applied
    chk("to_flag_cleared", 16'(timeout_flag), 16'd0);
    timeout_clr = 1'b0;
    chk("to_clr_once", 16'(int_button_clr), 16'd0);

    // Ack on the 4th presented cycle (collides with timeout): ack wins.
    // dispatch_ena dropped mid-presentation must not abort.
    int_button_sts = 5'h02;
    wait_valid("col_valid");                  // PRESENT #1
    dispatch_ena = 1'b0;
    tick();                                   // #2
    tick();                                   // #3
    tick();                                   // #4
    chk("col_valid4", 16'(irq_valid), 16'd1);
    irq_ack = 1'b1;
    tick();                                   // CLEAR
    irq_ack = 1'b0;
    chk("col_clr", 16'(int_button_clr), 16'h02);
    chk("col_flag", 16'(timeout_flag), 16'd0);
    chk("col_svc", svc_count, 16'd2);
    int_button_sts = 5'h00;
    tick();

    // Enable gating, stray ack ignored, then reset during PRESENT
    int_switch_sts = 8'h10;
    irq_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("en_blocked", 16'(irq_valid), 16'd0);
    end
    chk("en_svc_unchanged", svc_count, 16'd2);
    irq_ack = 1'b0;
    dispatch_ena = 1'b1;
    wait_valid("en_valid");
    chk("en_id", 16'(irq_id), 16'd4);
    res_n = 1'b0;
    tick();
    chk("mr_valid", 16'(irq_valid), 16'd0);
    chk("mr_id", 16'(irq_id), 16'd0);
    chk("mr_clr", 16'({int_button_clr, int_switch_clr}), 16'd0);
    chk("mr_svc", svc_count, 16'd0);
    res_n = 1'b1;
    int_switch_sts = 8'h00;
    tick();
    chk("mr_clr_after", 16'({int_button_clr, int_switch_clr}), 16'd0);
    tick();
    chk("mr_clr_after2", 16'({int_button_clr, int_switch_clr}), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
